// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding and the NOP opcode
// that a bubbled pipeline register carries.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [6:0] NOP_OPCODE = 7'h13;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freezes with a timeout into a sticky error state.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read_en,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_flush,
    output logic             ex_mem_write_en,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt_total
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t          r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_err;

    logic w_load_use;
    logic w_mem_busy;
    logic w_active;
    logic w_inc_stall;
    logic w_inc_flush;
    logic w_inc_wait;

    assign w_load_use = ex_mem_read_en && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign w_mem_busy = dmem_req && !dmem_ready;
    assign w_active   = (r_state != ST_ERROR);

    // Counters only see hazards that actually reach the pipeline controls.
    assign w_inc_wait  = w_active && w_mem_busy;
    assign w_inc_flush = w_active && !w_mem_busy && branch_taken_ex;
    assign w_inc_stall = w_active && !w_mem_busy && !branch_taken_ex && w_load_use;

    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_flush    = 1'b0;
        if (!w_active || w_mem_busy) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_flush    = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_mem_busy) begin
                        if (r_wait_cnt == WC_W'(TIMEOUT)) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign state           = r_state;
    assign mem_timeout_err = r_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_inc_stall),
        .o_count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_inc_flush),
        .o_count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_inc_wait),
        .o_count (wait_cnt_total)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a full-width instance and a 2-bit-counter
// instance share the same stimulus; both use a 4-cycle memory timeout.
module tb_pipeline_ctrl;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
    localparam logic [6:0] C_NORM   = 7'b1101010;
    localparam logic [6:0] C_STALL  = 7'b0001110;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read_en, branch_taken_ex, dmem_req, dmem_ready;

    logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en;
    logic        id_ex_flush, ex_mem_write_en, mem_wb_flush, mem_timeout_err;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt_total;

    logic        s_pc_we, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_fl, s_exmem_we, s_memwb_fl, s_err;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;

    pipeline_ctrl #(.CNT_W(16), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read_en(ex_mem_read_en), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
        .id_ex_write_en(id_ex_write_en), .id_ex_flush(id_ex_flush),
        .ex_mem_write_en(ex_mem_write_en), .mem_wb_flush(mem_wb_flush),
        .state(state), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_total(wait_cnt_total)
    );

    pipeline_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_dut_small (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read_en(ex_mem_read_en), .ex_rd(ex_rd),
        .branch_taken_ex(branch_taken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(s_pc_we), .if_id_write_en(s_ifid_we), .if_id_flush(s_ifid_fl),
        .id_ex_write_en(s_idex_we), .id_ex_flush(s_idex_fl),
        .ex_mem_write_en(s_exmem_we), .mem_wb_flush(s_memwb_fl),
        .state(s_state), .mem_timeout_err(s_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .wait_cnt_total(s_wait_cnt)
    );

    logic [6:0] w_ctrl, w_s_ctrl;
    assign w_ctrl   = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
                       id_ex_flush, ex_mem_write_en, mem_wb_flush};
    assign w_s_ctrl = {s_pc_we, s_ifid_we, s_ifid_fl, s_idex_we, s_idex_fl, s_exmem_we, s_memwb_fl};

    int n_total = 0;
    int n_bad   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic ld,
                          input logic [4:0] rd, input logic br, input logic req, input logic rdy);
        id_rs1          = rs1;
        id_rs2          = rs2;
        ex_mem_read_en  = ld;
        ex_rd           = rd;
        branch_taken_ex = br;
        dmem_req        = req;
        dmem_ready      = rdy;
    endtask

    // One clock: drive inputs, queue the expected controls, compare mid-cycle.
    task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ld, input logic [4:0] rd, input logic br,
                       input logic req, input logic rdy,
                       input logic [6:0] e_ctrl, input logic [1:0] e_st, input logic e_err);
        logic [9:0] e;
        set_in(rs1, rs2, ld, rd, br, req, rdy);
        exp_q.push_back({e_ctrl, e_st, e_err});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".ctrl"}, 32'(w_ctrl), 32'(e[9:3]));
        check({tag, ".state"}, 32'(state), 32'(e[2:1]));
        check({tag, ".err"}, 32'(mem_timeout_err), 32'(e[0]));
        check({tag, ".s_ctrl"}, 32'(w_s_ctrl), 32'(e[9:3]));
        check({tag, ".s_state"}, 32'(s_state), 32'(e[2:1]));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [1:0] e_st);
        cyc(tag, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, e_st, 1'b0);
    endtask

    task automatic check_cnts(input string tag, input int e_stall, input int e_flush, input int e_wait);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), e_stall);
        check({tag, ".flush_cnt"}, 32'(flush_cnt), e_flush);
        check({tag, ".wait_cnt"}, 32'(wait_cnt_total), e_wait);
        check({tag, ".s_stall_cnt"}, 32'(s_stall_cnt), (e_stall > 3) ? 3 : e_stall);
        check({tag, ".s_flush_cnt"}, 32'(s_flush_cnt), (e_flush > 3) ? 3 : e_flush);
        check({tag, ".s_wait_cnt"}, 32'(s_wait_cnt), (e_wait > 3) ? 3 : e_wait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst.state", 32'(state), 32'(S_RUN));
        check("rst.err", 32'(mem_timeout_err), 0);
        check("rst.ctrl", 32'(w_ctrl), 32'(C_NORM));
        check_cnts("rst", 0, 0, 0);

        // Reset still shows RUN controls for the live inputs, but counts nothing.
        set_in(5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_lu.ctrl", 32'(w_ctrl), 32'(C_STALL));
        @(posedge clk);
        #1;
        check_cnts("rst_lu", 0, 0, 0);
        rst = 1'b1;

        // Case 1: load-use on rs1
        cyc("c1", 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN, 1'b0);
        idle("c1_idle", S_RUN);
        check_cnts("c1", 1, 0, 0);

        // Case 2: x0 never hazards; rs2 match stalls; no load flag no stall
        cyc("c2_x0", 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, S_RUN, 1'b0);
        cyc("c2_rs2", 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN, 1'b0);
        cyc("c2_nold", 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, S_RUN, 1'b0);
        check_cnts("c2", 2, 0, 0);

        // Case 3: branch wins over load-use
        cyc("c3", 5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, C_FLUSH, S_RUN, 1'b0);
        check_cnts("c3", 2, 1, 0);

        // Case 4: three frozen cycles, then release
        cyc("c4_f1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_RUN, 1'b0);
        cyc("c4_f2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_WAIT, 1'b0);
        cyc("c4_f3", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_WAIT, 1'b0);
        cyc("c4_rel", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM, S_WAIT, 1'b0);
        idle("c4_run", S_RUN);
        check_cnts("c4", 2, 1, 3);

        // Freeze masks branch and load-use; the release cycle applies the branch
        cyc("c4b_f", 5'd6, 5'd0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, C_FREEZE, S_RUN, 1'b0);
        cyc("c4b_rel", 5'd6, 5'd0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, C_FLUSH, S_WAIT, 1'b0);
        idle("c4b_run", S_RUN);
        check_cnts("c4b", 2, 2, 4);

        // Case 5: memory never ready -> ERROR after the wait counter hits 4
        cyc("c5_w1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_RUN, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            cyc($sformatf("c5_w%0d", i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
                C_FREEZE, S_WAIT, 1'b0);
        end
        cyc("c5_err1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_FREEZE, S_ERR, 1'b1);
        cyc("c5_err2", 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C_FREEZE, S_ERR, 1'b1);
        check_cnts("c5", 2, 2, 9);
        check("c5.s_err", 32'(s_err), 1);

        // Reset out of ERROR takes effect without a clock
        rst = 1'b0;
        #1;
        check("c5_rst.state", 32'(state), 32'(S_RUN));
        check("c5_rst.err", 32'(mem_timeout_err), 0);
        check("c5_rst.ctrl", 32'(w_ctrl), 32'(C_FLUSH));
        check_cnts("c5_rst", 0, 0, 0);
        rst = 1'b1;
        idle("c5_run", S_RUN);

        // Case 6: five stalls saturate the 2-bit counter; four flushes likewise
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("c6_st%0d", i), 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0,
                C_STALL, S_RUN, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("c6_br%0d", i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
                C_FLUSH, S_RUN, 1'b0);
        end
        check_cnts("c6", 5, 4, 0);

        // Reset asserted mid-MEM_WAIT
        cyc("c7_f1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_RUN, 1'b0);
        cyc("c7_f2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_WAIT, 1'b0);
        check("c7_pre.state", 32'(state), 32'(S_WAIT));
        rst = 1'b0;
        #1;
        check("c7_rst.state", 32'(state), 32'(S_RUN));
        check("c7_rst.ctrl", 32'(w_ctrl), 32'(C_FREEZE));
        check_cnts("c7_rst", 0, 0, 0);
        rst = 1'b1;
        idle("c7_run", S_RUN);
        cyc("c7_f3", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FREEZE, S_RUN, 1'b0);
        cyc("c7_rel", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, S_WAIT, 1'b0);
        idle("c7_end", S_RUN);
        check_cnts("c7", 0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
